muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be, clock and reset first:
  - clk  input  1  sole clock, rising edge
  - reset_n  input  1  asynchronous, active-low reset
  - start  input  1  request to begin an operation, sampled only in IDLE
  - op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
  - opa  input  32  multiplicand or dividend
  - opb  input  32  multiplier or divisor
  - cancel  input  1  pipeline flush; abort any operation
  - busy  output  1  high whenever state != IDLE; the pipeline stalls on it
  - whilo  output  1  one-cycle write strobe to the HI/LO register
  - hi_o  output  32  HI write data: product[63:32] or remainder
  - lo_o  output  32  LO write data: product[31:0] or quotient

Function
REQ-003 The state machine SHALL have four states: IDLE, MUL, DIV and DONE.
REQ-004 In IDLE, start=1 with cancel=0 SHALL latch op, opa and opb at that edge (E0).
REQ-005 From IDLE, a DIV/DIVU start with opb=0 SHALL go to DONE.
REQ-006 From IDLE, any other DIV/DIVU start SHALL go to DIV.
REQ-007 From IDLE, a MULT/MULTU start SHALL go to MUL, or to DONE when MULDIV_FAST_MULT_EN is defined.
REQ-008 MUL SHALL run a shift-add loop for exactly 32 cycles, then go to DONE.
REQ-009 DIV SHALL run a radix-2 restoring divide for exactly 32 cycles, then go to DONE.
REQ-010 The iteration counter SHALL be 5 bits, clear on entry to MUL or DIV, and leave on count 31.
REQ-011 DONE SHALL last exactly one cycle and SHALL always return to IDLE.
REQ-012 whilo SHALL equal (state==DONE) & ~cancel, so it is high for at most one cycle per operation.
REQ-013 hi_o and lo_o SHALL be registered and stable for the whole DONE cycle.
REQ-014 Latency from E0 to the whilo cycle SHALL be:
  - 33 cycles for DIV/DIVU
  - 33 cycles for iterative MULT/MULTU
  - 1 cycle for fast multiply
  - 1 cycle for divide by zero
REQ-015 MULTU and DIVU SHALL treat both operands as unsigned.
REQ-016 MULT and DIV SHALL operate on absolute values, then fix the signs:
  - product or quotient negated when the operand signs differ
  - remainder takes the sign of the dividend
REQ-017 The product SHALL be 64 bits wide; {hi_o,lo_o} = product.
REQ-018 Divide by zero SHALL give hi_o=opa and lo_o=32'hFFFF_FFFF.
REQ-019 DIV of 32'h8000_0000 by 32'hFFFF_FFFF SHALL give lo_o=32'h8000_0000 and hi_o=0.
REQ-020 start while busy=1 SHALL be ignored; no queueing.
REQ-021 cancel=1 in any state SHALL force IDLE at the next edge, with no whilo, and latched data discarded.
REQ-022 When cancel and start are both high in IDLE, cancel SHALL win and start SHALL be ignored.
REQ-023 A new start SHALL be accepted in the first IDLE cycle after DONE or after a cancel; no gap is required.

Reset
REQ-024 reset_n=0 SHALL asynchronously force:
  - state to IDLE
  - counter, busy and whilo to 0
  - hi_o, lo_o and all internal operand/partial registers to 32'h0
REQ-025 Reset asserted mid-operation SHALL abort without any whilo pulse, either during reset or after release.
REQ-026 The first start SHALL be accepted at the first rising edge after reset_n deasserts.

Configuration
REQ-027 The macro MULDIV_FAST_MULT_EN SHALL select the multiply implementation.
REQ-028 When MULDIV_FAST_MULT_EN is defined:
  - MULT/MULTU use a single-cycle 32x32 array multiply
  - the result is registered at E0+1 and the state goes directly to DONE
  - the MUL state and its datapath are omitted
REQ-029 When MULDIV_FAST_MULT_EN is undefined, multiply SHALL use the 32-cycle iterative path.
REQ-030 Divide behaviour SHALL be identical in both builds.

Verification
REQ-031 MULT opa=32'hFFFF_FFFD (-3), opb=5 -> one whilo pulse with hi_o=32'hFFFF_FFFF, lo_o=32'hFFFF_FFF1; at E0+33 (iterative) or E0+1 (fast).
REQ-032 DIVU opa=100, opb=7 -> busy high for 33 cycles, whilo at E0+33 with lo_o=14, hi_o=2.
REQ-033 DIV opa=-7, opb=2 -> lo_o=32'hFFFF_FFFD (-3), hi_o=32'hFFFF_FFFF (-1).
REQ-034 DIVU opa=32'h1234, opb=0 -> whilo at E0+1 with hi_o=32'h1234, lo_o=32'hFFFF_FFFF.
REQ-035 DIV started, then cancel pulsed at E0+10 -> IDLE at E0+11, busy low, no whilo; a new MULTU 3*4 then gives lo_o=12, hi_o=0.
REQ-036 Each of the following yields exactly one whilo for the first operation only:
  - start held high through a whole DIVU
  - reset_n pulsed low at E0+5 (this instead yields no whilo at all)

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that produces the HI/LO write data.
// Defining MULDIV_FAST_MULT_EN switches multiply to a single-cycle array multiplier.
module muldiv_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    output logic        busy,
    output logic        whilo,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
`ifdef MULDIV_FAST_MULT_EN
    localparam state_t MUL_GO = DONE;
`else
    localparam state_t MUL_GO = MUL;
`endif
    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] d_q, acc_hi, acc_lo;
    logic        neg_q, rneg_q;
    logic        is_div, sgn, sa, sb, div0;
    logic [31:0] ma, mb;
    logic [32:0] shl, sub;
    logic        ge;
    logic [31:0] div_hi, div_lo;
    assign is_div = op[1];
    assign sgn    = ~op[0];
    assign sa     = sgn & opa[31];
    assign sb     = sgn & opb[31];
    assign ma     = sa ? -opa : opa;
    assign mb     = sb ? -opb : opb;
    assign div0   = is_div && opb == '0;
    // Restoring step: a borrow out of the trial subtract means the divisor did not fit.
    assign shl    = {acc_hi, acc_lo[31]};
    assign sub    = shl - {1'b0, d_q};
    assign ge     = ~sub[32];
    assign div_hi = ge ? sub[31:0] : shl[31:0];
    assign div_lo = {acc_lo[30:0], ge};
`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fprod, fres;
    assign fprod = {32'b0, ma} * {32'b0, mb};
    assign fres  = (sa ^ sb) ? -fprod : fprod;
`else
    logic [32:0] msum;
    logic [31:0] mul_hi, mul_lo;
    logic [63:0] mul_p;
    assign msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, d_q} : 33'd0);
    assign mul_hi = msum[32:1];
    assign mul_lo = {msum[0], acc_lo[31:1]};
    assign mul_p  = {mul_hi, mul_lo};
`endif
    always_comb begin
        state_nxt = state;
        busy      = state != IDLE;
        whilo     = state == DONE && !cancel;
        case (state)
            IDLE:    if (start) state_nxt = !is_div ? MUL_GO : div0 ? DONE : DIV;
            MUL:     if (cnt == 5'd31) state_nxt = DONE;
            DIV:     if (cnt == 5'd31) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (cancel) state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 5'd0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == MUL || state == DIV) && !cancel ? cnt + 5'd1 : 5'd0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else if (!cancel) begin
            if (state == IDLE && start) begin
                neg_q  <= sa ^ sb;
                rneg_q <= sa;
                d_q    <= is_div ? mb : ma;
                acc_hi <= '0;
                acc_lo <= is_div ? ma : mb;
                if (div0) begin
                    hi_o <= opa;
                    lo_o <= '1;
                end
`ifdef MULDIV_FAST_MULT_EN
                else if (!is_div) {hi_o, lo_o} <= fres;
`endif
            end else if (state == DIV) begin
                acc_hi <= div_hi;
                acc_lo <= div_lo;
                if (cnt == 5'd31) begin
                    hi_o <= rneg_q ? -div_hi : div_hi;
                    lo_o <= neg_q ? -div_lo : div_lo;
                end
            end
`ifndef MULDIV_FAST_MULT_EN
            else if (state == MUL) begin
                acc_hi <= mul_hi;
                acc_lo <= mul_lo;
                if (cnt == 5'd31) {hi_o, lo_o} <= neg_q ? -mul_p : mul_p;
            end
`endif
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized and directed checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    logic        clk, reset_n, start, cancel, busy, whilo;
    logic [1:0]  op;
    logic [31:0] opa, opb, hi_o, lo_o;
    int n_tests = 0;
    int n_fail  = 0;

    muldiv_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .opa(opa), .opb(opb),
        .cancel(cancel), .busy(busy), .whilo(whilo), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output int lat);
        longint sa, sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        h = '0;
        l = '0;
        lat = 33;
        if (o[1] && b == 0) begin
            h = a;
            l = 32'hFFFF_FFFF;
            lat = 1;
        end else if (o == 2'd0 || o == 2'd1) begin
            p = (o == 2'd0) ? 64'(sa * sb) : {32'b0, a} * {32'b0, b};
            {h, l} = p;
            lat = MUL_LAT;
        end else if (o == 2'd2) begin
            l = 32'(sa / sb);
            h = 32'(sa % sb);
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction

    // Launches one operation and watches a 40-cycle window after the accepting edge E0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int hold, input int rst_at,
                          output int np, output int lat, output int bc,
                          output logic [31:0] h, output logic [31:0] l);
        @(negedge clk);
        op = o; opa = a; opb = b; start = 1'b1;
        @(posedge clk);
        np = 0; lat = -1; bc = 0; h = '0; l = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (whilo) begin
                np++;
                if (lat < 0) begin
                    lat = k; h = hi_o; l = lo_o;
                end
            end
            if (busy) bc++;
            start  = (k < hold);
            cancel = (k == cancel_at);
            if (k == rst_at) reset_n = 1'b0;
            if (k == rst_at + 2) reset_n = 1'b1;
        end
        start = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b1; cancel = 1'b0; op = 2'd3; opa = 32'h55; opb = 32'h0;
        #12;
        n_tests++;
        if ({busy, whilo} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ctl busy/whilo=%b required 00", {busy, whilo});
        end
        n_tests++;
        if ({hi_o, lo_o} !== 64'h0) begin
            n_fail++; $display("FAIL reset_data hi=%h lo=%h required 0/0", hi_o, lo_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (whilo !== 1'b1 || hi_o !== 32'h55 || lo_o !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL first_start whilo=%b hi=%h lo=%h required 1/00000055/ffffffff", whilo, hi_o, lo_o);
        end
        @(negedge clk);
        n_tests++;
        if ({busy, whilo} !== 2'b00) begin
            n_fail++; $display("FAIL done_one_cycle busy/whilo=%b required 00", {busy, whilo});
        end
    endtask

    task automatic test_directed;
        logic [1:0]  dop[5] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd2};
        logic [31:0] da[5]  = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000};
        logic [31:0] db[5]  = '{32'd5, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] dh[5]  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h0};
        logic [31:0] dl[5]  = '{32'hFFFF_FFF1, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int          dlat[5] = '{MUL_LAT, 33, 33, 1, 33};
        int np, lat, bc;
        logic [31:0] h, l;
        for (int i = 0; i < 5; i++) begin
            run_op(dop[i], da[i], db[i], 0, 0, 0, np, lat, bc, h, l);
            n_tests++;
            if (np !== 1 || lat !== dlat[i] || h !== dh[i] || l !== dl[i]) begin
                n_fail++;
                $display("FAIL directed[%0d] np=%0d lat=%0d hi=%h lo=%h required 1/%0d/%h/%h",
                         i, np, lat, h, l, dlat[i], dh[i], dl[i]);
            end
            n_tests++;
            if (bc !== dlat[i]) begin
                n_fail++; $display("FAIL directed_busy[%0d] busy cycles=%0d required %0d", i, bc, dlat[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] a, b, eh, el, h, l;
        int elat, np, lat, bc;
        for (int i = 0; i < 60; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            model(o, a, b, eh, el, elat);
            run_op(o, a, b, 0, 0, 0, np, lat, bc, h, l);
            n_tests++;
            if (np !== 1 || lat !== elat || h !== eh || l !== el || bc !== elat) begin
                n_fail++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: np=%0d lat=%0d busy=%0d hi=%h lo=%h required 1/%0d/%0d/%h/%h",
                         i, o, a, b, np, lat, bc, h, l, elat, elat, eh, el);
            end
        end
    endtask

    task automatic test_cancel;
        int np, lat, bc;
        logic [31:0] h, l;
        run_op(2'd2, 32'd1000, 32'd3, 11, 0, 0, np, lat, bc, h, l);
        n_tests++;
        if (np !== 0 || bc !== 11 || busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel np=%0d busy cycles=%0d busy=%b required 0/11/0", np, bc, busy);
        end
        run_op(2'd1, 32'd3, 32'd4, 0, 0, 0, np, lat, bc, h, l);
        n_tests++;
        if (np !== 1 || h !== 32'd0 || l !== 32'd12) begin
            n_fail++; $display("FAIL after_cancel np=%0d hi=%h lo=%h required 1/0/c", np, h, l);
        end
        @(negedge clk);
        start = 1'b1; cancel = 1'b1; op = 2'd3; opa = 32'h77; opb = 32'h0;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        n_tests++;
        if ({busy, whilo} !== 2'b00 || hi_o !== 32'h0) begin
            n_fail++; $display("FAIL cancel_wins busy/whilo=%b hi=%h required 00/0", {busy, whilo}, hi_o);
        end
    endtask

    task automatic test_back_to_back;
        int np, lat, bc;
        logic [31:0] h, l;
        run_op(2'd3, 32'd1000, 32'd9, 0, 34, 0, np, lat, bc, h, l);
        n_tests++;
        if (np !== 1 || lat !== 33 || bc !== 33 || h !== 32'd1 || l !== 32'd111) begin
            n_fail++;
            $display("FAIL start_held np=%0d lat=%0d busy=%0d hi=%h lo=%h required 1/33/33/1/6f", np, lat, bc, h, l);
        end
        run_op(2'd3, 32'd50, 32'd0, 0, 0, 0, np, lat, bc, h, l);
        n_tests++;
        if (np !== 1 || lat !== 1 || h !== 32'd50) begin
            n_fail++; $display("FAIL no_gap np=%0d lat=%0d hi=%h required 1/1/32", np, lat, h);
        end
    endtask

    task automatic test_reset_mid;
        int np, lat, bc;
        logic [31:0] h, l;
        run_op(2'd3, 32'd1000, 32'd7, 0, 0, 5, np, lat, bc, h, l);
        n_tests++;
        if (np !== 0 || busy !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid np=%0d busy=%b hi=%h lo=%h required 0/0/0/0", np, busy, hi_o, lo_o);
        end
        run_op(2'd0, 32'h8000_0000, 32'd2, 0, 0, 0, np, lat, bc, h, l);
        n_tests++;
        if (np !== 1 || lat !== MUL_LAT || h !== 32'hFFFF_FFFF || l !== 32'h0) begin
            n_fail++;
            $display("FAIL after_reset np=%0d lat=%0d hi=%h lo=%h required 1/%0d/ffffffff/0", np, lat, h, l, MUL_LAT);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_cancel;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
